// File: rtl/display_pkg.sv
// Shared display definitions: mode encodings, segment/anode constants and helpers.
// Also used by the switch-mode decoder, so the encodings must stay stable.
package display_pkg;

   typedef enum logic [1:0] {
      MODE_AB    = 2'b00,
      MODE_C     = 2'b01,
      MODE_D     = 2'b10,
      MODE_BLANK = 2'b11
   } display_mode_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [3:0] ANODE_OFF = 4'hF;

   // Slot 0 is the leftmost digit, which sits on an[3].
   function automatic logic [3:0] anode_for_slot(input logic [1:0] slot);
      return ~(4'b1000 >> slot);
   endfunction

   // Bit k set means slot k holds a leading zero; slot 3 is never suppressed.
   function automatic logic [3:0] leading_zero_mask(input logic [15:0] value);
      logic [3:0] mask;
      mask[0] = (value[15:12] == 4'h0);
      mask[1] = mask[0] && (value[11:8] == 4'h0);
      mask[2] = mask[1] && (value[7:4] == 4'h0);
      mask[3] = 1'b0;
      return mask;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low {g,f,e,d,c,b,a} decoder.
// Codes 10-15 are not valid BCD and show a dash.
module bcd_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (nibble)
         4'd0: seg = 7'h40;
         4'd1: seg = 7'h79;
         4'd2: seg = 7'h24;
         4'd3: seg = 7'h30;
         4'd4: seg = 7'h19;
         4'd5: seg = 7'h12;
         4'd6: seg = 7'h02;
         4'd7: seg = 7'h78;
         4'd8: seg = 7'h00;
         4'd9: seg = 7'h10;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit multiplexed 7-segment driver with a per-frame snapshot of mode and data.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros in the C and D modes.
module display_scan_mux
   import display_pkg::*;
#(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mode,
   input  logic [7:0]  digits_A,
   input  logic [7:0]  digits_B,
   input  logic [15:0] digits_C,
   input  logic [15:0] digits_D,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);

   localparam int DIV_W = $clog2(REFRESH_DIV);

   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       dig_idx;
   logic             div_term;
   logic             frame_end;
   display_mode_e    mode_q;
   logic [7:0]       a_q;
   logic [7:0]       b_q;
   logic [15:0]      c_q;
   logic [15:0]      d_q;
   logic [3:0]       nibble;
   logic [6:0]       seg_dec;
   logic             slot_dp;
   logic             slot_lit;
   logic             slot_suppressed;

   assign div_term  = (div_cnt == DIV_W'(REFRESH_DIV - 1));
   assign frame_end = div_term && (dig_idx == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         dig_idx <= 2'd0;
      end else if (div_term) begin
         div_cnt <= '0;
         dig_idx <= dig_idx + 2'd1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // The snapshot is only refreshed at the frame boundary so a frame never mixes old and new data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= MODE_BLANK;
         a_q        <= 8'h00;
         b_q        <= 8'h00;
         c_q        <= 16'h0000;
         d_q        <= 16'h0000;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_end;
         if (frame_end) begin
            mode_q <= display_mode_e'(mode);
            a_q    <= digits_A;
            b_q    <= digits_B;
            c_q    <= digits_C;
            d_q    <= digits_D;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [3:0] zero_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_mask <= 4'h0;
      end else if (frame_end) begin
         if (mode == MODE_C) begin
            zero_mask <= leading_zero_mask(digits_C);
         end else if (mode == MODE_D) begin
            zero_mask <= leading_zero_mask(digits_D);
         end else begin
            zero_mask <= 4'h0;
         end
      end
   end

   assign slot_suppressed = zero_mask[dig_idx];
`else
   assign slot_suppressed = 1'b0;
`endif

   // Every mode is a 16-bit word read MSB nibble first, so one shift serves them all.
   always_comb begin
      nibble   = 4'h0;
      slot_dp  = 1'b1;
      slot_lit = 1'b1;
      case (mode_q)
         MODE_AB: begin
            nibble  = 4'({a_q, b_q} >> {~dig_idx, 2'b00});
            slot_dp = (dig_idx != 2'd1);
         end
         MODE_C:  nibble = 4'(c_q >> {~dig_idx, 2'b00});
         MODE_D:  nibble = 4'(d_q >> {~dig_idx, 2'b00});
         default: slot_lit = 1'b0;
      endcase
      if (slot_suppressed) begin
         slot_lit = 1'b0;
      end
   end

   bcd_to_7seg u_decoder (
      .nibble (nibble),
      .seg    (seg_dec)
   );

   // The dark window at the start of each slot hides ghosting while anodes switch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= ANODE_OFF;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else if ((div_cnt < DIV_W'(BLANK_CYCLES)) || !slot_lit) begin
         an  <= ANODE_OFF;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= anode_for_slot(dig_idx);
         seg <= seg_dec;
         dp  <= slot_dp;
      end
   end

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: a time-based reference model queues the expected
// outputs after each clock edge and a negedge monitor compares them against the DUT.
module tb_display_scan_mux;

   localparam int REFRESH_DIV  = 8;
   localparam int BLANK_CYCLES = 2;
   localparam int FRAME        = 4 * REFRESH_DIV;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic [7:0]  digits_A;
   logic [7:0]  digits_B;
   logic [15:0] digits_C;
   logic [15:0] digits_D;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_tick;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       frame_tick;
   } expect_t;

   localparam expect_t EXP_BLANK = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, frame_tick: 1'b0};

   expect_t     exp_q[$];
   int          checks = 0;
   int          passes = 0;
   int unsigned edge_count = 0;
   int          snap_mode = 3;
   int          snap_nib[4] = '{0, 0, 0, 0};
   logic [6:0]  seg_table[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   always #5 clk = ~clk;

   display_scan_mux #(
      .REFRESH_DIV  (REFRESH_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .digits_A   (digits_A),
      .digits_B   (digits_B),
      .digits_C   (digits_C),
      .digits_D   (digits_D),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   // What the display should show for a given slot and position within it, from the current frame.
   function automatic expect_t slot_expect(int slot, int phase);
      expect_t e;
      bit      lit;
      int      nib;
      e   = EXP_BLANK;
      lit = (phase >= BLANK_CYCLES) && (snap_mode != 3);
`ifdef LEADING_ZERO_BLANK_EN
      if (snap_mode == 1 || snap_mode == 2) begin
         bit leading = 1'b1;
         for (int k = 0; k <= slot; k++) begin
            if (snap_nib[k] != 0) leading = 1'b0;
         end
         if (slot < 3 && leading) lit = 1'b0;
      end
`endif
      if (lit) begin
         nib   = snap_nib[slot];
         e.an  = 4'hF & ~(4'b0001 << (3 - slot));
         e.seg = (nib < 10) ? seg_table[nib] : 7'h3F;
         e.dp  = !(snap_mode == 0 && slot == 1);
      end
      return e;
   endfunction

   function automatic void take_snapshot();
      snap_mode = int'(mode);
      case (snap_mode)
         0: begin
            snap_nib[0] = int'(digits_A[7:4]);
            snap_nib[1] = int'(digits_A[3:0]);
            snap_nib[2] = int'(digits_B[7:4]);
            snap_nib[3] = int'(digits_B[3:0]);
         end
         1: for (int k = 0; k < 4; k++) snap_nib[k] = int'((digits_C >> (12 - 4 * k)) & 16'hF);
         2: for (int k = 0; k < 4; k++) snap_nib[k] = int'((digits_D >> (12 - 4 * k)) & 16'hF);
         default: for (int k = 0; k < 4; k++) snap_nib[k] = 0;
      endcase
   endfunction

   // Reference model: elapsed edges since reset release decide slot, phase and frame boundaries.
   always @(posedge clk or posedge rst) begin
      expect_t e;
      int      slot;
      int      phase;
      if (rst) begin
         edge_count = 0;
         snap_mode  = 3;
         for (int k = 0; k < 4; k++) snap_nib[k] = 0;
         exp_q.delete();
         exp_q.push_back(EXP_BLANK);
      end else begin
         slot  = int'((edge_count / REFRESH_DIV) % 4);
         phase = int'(edge_count % REFRESH_DIV);
         e     = slot_expect(slot, phase);
         if (slot == 3 && phase == REFRESH_DIV - 1) begin
            take_snapshot();
            e.frame_tick = 1'b1;
         end
         exp_q.push_back(e);
         edge_count++;
      end
   end

   task automatic check_field(input string name, input int actual, input int required);
      checks++;
      if (actual == required) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, required, $time);
      end
   endtask

   task automatic check_output(input expect_t e);
      check_field("an", int'(an), int'(e.an));
      check_field("seg", int'(seg), int'(e.seg));
      check_field("dp", int'(dp), int'(e.dp));
      check_field("frame_tick", int'(frame_tick), int'(e.frame_tick));
   endtask

   always @(negedge clk) begin
      expect_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_output(e);
      end
   end

   task automatic apply_stimulus(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                                 input logic [15:0] c, input logic [15:0] d);
      mode     = m;
      digits_A = a;
      digits_B = b;
      digits_C = c;
      digits_D = d;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_slot(input int slot, input int phase);
      bit found = 1'b0;
      for (int i = 0; i < 4 * FRAME; i++) begin
         if (int'((edge_count / REFRESH_DIV) % 4) == slot && int'(edge_count % REFRESH_DIV) == phase) begin
            found = 1'b1;
            break;
         end
         wait_cycles(1);
      end
      if (!found) check_field("wait_slot_timeout", 0, 1);
   endtask

   initial begin
      rst = 1'b1;
      apply_stimulus(2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000);
      wait_cycles(3);

      $display("[TB] A&B pair 12|34 after reset");
      apply_stimulus(2'b00, 8'h12, 8'h34, 16'h0000, 16'h0000);
      rst = 1'b0;
      wait_cycles(2 * FRAME);

      $display("[TB] C = 0907");
      apply_stimulus(2'b01, 8'h12, 8'h34, 16'h0907, 16'h0000);
      wait_cycles(2 * FRAME);

      $display("[TB] D = A000");
      apply_stimulus(2'b10, 8'h12, 8'h34, 16'h0907, 16'hA000);
      wait_cycles(2 * FRAME);

      $display("[TB] mode 00 -> 11 mid-frame");
      apply_stimulus(2'b00, 8'h56, 8'h78, 16'h0907, 16'hA000);
      wait_cycles(FRAME);
      wait_slot(1, 3);
      mode = 2'b11;
      wait_cycles(2 * FRAME);

      $display("[TB] C 1111 -> 2222 during slot 2");
      apply_stimulus(2'b01, 8'h56, 8'h78, 16'h1111, 16'hA000);
      wait_cycles(FRAME);
      wait_slot(2, 4);
      digits_C = 16'h2222;
      wait_cycles(2 * FRAME);

      $display("[TB] randomized mode and data");
      repeat (40) begin
         apply_stimulus(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                        16'($urandom), 16'($urandom));
         if ($urandom_range(0, 3) == 0) digits_C = 16'($urandom_range(0, 99));
         if ($urandom_range(0, 3) == 0) digits_D = 16'($urandom_range(0, 9));
         wait_cycles(int'($urandom_range(1, 24)));
      end

      $display("[TB] reset during a lit slot");
      apply_stimulus(2'b00, 8'h98, 8'h76, 16'h0000, 16'h0000);
      wait_cycles(FRAME);
      wait_slot(1, 5);
      rst = 1'b1;
      wait_cycles(3);
      rst = 1'b0;
      wait_cycles(FRAME + 16);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Downstream consumer of the 2-bit display mode from the switch-mode decoder.
- Selects the digit source for the mode: A&B pair (counters), C (coincidence count), D (TDC measurement), or blank.
- Time-multiplexes the selected digits onto a 4-digit common-anode 7-segment display.
- Snapshots mode and digit data once per refresh frame so the display never tears mid-frame.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot (minimum 4).
- BLANK_CYCLES, 500, cycles at start of each slot with all anodes off (anti-ghosting); must be less than REFRESH_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- mode  input  2  00=A&B, 01=C, 10=D, 11=blank
- digits_A  input  8  two BCD digits, [7:4] most significant
- digits_B  input  8  two BCD digits
- digits_C  input  16  four BCD digits, [15:12] most significant
- digits_D  input  16  four BCD digits
- an  output  4  anode enables, active-low, an[3]=leftmost
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- frame_tick  output  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - an=4'hF, seg=7'h7F, dp=1, frame_tick=0.
  - div_cnt=0, dig_idx=0.
  - snapshot: mode_q=2'b11 (blank), data snapshot cleared.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1 and then wraps to 0.
  - At terminal count, dig_idx advances 0->1->2->3->0.
  - dig_idx 0 drives an[3]; dig_idx 3 drives an[0].
- Frame snapshot:
  - Taken on the cycle where div_cnt is terminal and dig_idx==3.
  - Latches mode into mode_q and digits_A..D into the snapshot registers.
  - frame_tick pulses high on that same registered cycle.
- Slot output (registered, 1-cycle latency from div_cnt/dig_idx state):
  - div_cnt < BLANK_CYCLES: an=4'hF, seg=7'h7F, dp=1.
  - Otherwise: exactly one anode is low, and seg/dp come from the selected nibble.
- Nibble selection by mode_q, slots 0..3 left to right:
  - 00: A[7:4], A[3:0], B[7:4], B[3:0]. dp=0 on slot 1 only, as the A|B separator.
  - 01: C nibbles, MSB first. dp=1.
  - 10: D nibbles, MSB first. dp=1.
  - 11: an=4'hF, seg=7'h7F, dp=1 for the whole frame.
- Decode:
  - Nibble 0-9 gives the standard active-low pattern (0=7'h40, 1=7'h79, 8=7'h00, 9=7'h10).
  - Nibble 10-15 (invalid BCD) shows a dash, 7'h3F.
- A mode change mid-frame has no visible effect until the next snapshot; the worst-case delay is 4*REFRESH_DIV+1 cycles.
- Input data changing mid-frame is likewise ignored until the next snapshot.
- Reset asserted mid-slot blanks the outputs immediately (asynchronous).
- After reset release, the first snapshot occurs 4*REFRESH_DIV-1 cycles later; the display stays blank until then.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Modes 01 and 10 blank leading zero nibbles (an high for those slots) up to, but not including, slot 3.
  - Value 0 therefore shows a single "0" in slot 3.
  - The zero-run is computed from the snapshot at snapshot time and registered as a 4-bit mask.
  - Mode 00 is unaffected.
- Undefined: all four digits are always shown, and no mask register exists.

Decomposition:
- Shared package display_pkg:
  - Mode encodings MODE_AB=2'b00, MODE_C=2'b01, MODE_D=2'b10, MODE_BLANK=2'b11 (shared with the mode decoder).
  - SEG_BLANK=7'h7F, SEG_DASH=7'h3F, ANODE_OFF=4'hF.
- Sub-module bcd_to_7seg: combinational nibble-to-active-low-segment decoder, instantiated once.

Test Plan (bench uses REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset, then release with mode=00, A=8'h12, B=8'h34:
  - Blank for 31 cycles, then frame_tick pulses once.
  - Slots show 1,2,3,4 with an=0111,1011,1101,1110.
  - dp=0 only while an=1011.
  - an=4'hF for 2 cycles at the start of each slot.
- mode=01, C=16'h0907: display shows 0,9,0,7; with LEADING_ZERO_BLANK_EN, an[3] stays high in slot 0.
- mode=10, D=16'hA000: slot 0 seg=7'h3F (dash), slots 1-3 seg=7'h40.
- Switch mode 00->11 while dig_idx=1: current frame completes with A/B data; after the next frame_tick, an=4'hF for the full frame.
- Change C from 16'h1111 to 16'h2222 during slot 2: remaining slots still show 1; the next frame shows 2 in all four slots.
- Assert rst during a lit slot: an=4'hF and seg=7'h7F in the same cycle; after release the divider restarts from 0 and the display stays blank until the first frame_tick.
